// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data-memory responder with fixed-latency ready/valid handshake
//
// Purpose: serves single-outstanding load/store requests from the memory stage.
//   A request is accepted when o_ready is high and i_read or i_write is set.
//   The response appears as a one-cycle o_valid pulse LATENCY edges after acceptance.
//   Optional feature macro: DMEM_ALIGN_CHECK_EN (adds o_error; misaligned accesses are flagged and suppressed).
// Ports:
//   i_clock       rising-edge clock
//   i_reset       asynchronous active-high reset
//   i_read        load request
//   i_write       store request (wins over i_read)
//   i_address     byte address of request
//   i_store_data  store word
//   o_ready       responder can accept a request this cycle
//   o_valid       one-cycle response pulse
//   o_load_data   load result, 0 for store responses
//   o_data_addr   address of the transaction being responded to
//   o_error       misaligned-access flag (DMEM_ALIGN_CHECK_EN only)
module data_mem_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int MEM_DEPTH_BITS = 10,
    parameter int LATENCY        = 2
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_read,
    input  logic                    i_write,
    input  logic [ADDRESS_BITS-1:0] i_address,
    input  logic [DATA_WIDTH-1:0]   i_store_data,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_load_data,
    output logic [ADDRESS_BITS-1:0] o_data_addr
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic                    o_error
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter start value on entering WAIT; unused when LATENCY is 1.
    localparam logic [3:0] LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t                    r_state;
    state_t                    w_next;
    logic [3:0]                r_count;
    logic [ADDRESS_BITS-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_is_write;
    logic [DATA_WIDTH-1:0]     r_load_data;
    logic [ADDRESS_BITS-1:0]   r_data_addr;
    logic [DATA_WIDTH-1:0]     r_mem [0:(1<<MEM_DEPTH_BITS)-1];

    logic                      w_ready;
    logic                      w_accept;
    logic                      w_enter_resp;
    logic [ADDRESS_BITS-1:0]   w_txn_addr;
    logic [DATA_WIDTH-1:0]     w_txn_data;
    logic                      w_txn_write;
    logic [MEM_DEPTH_BITS-1:0] w_idx;
    logic                      w_misaligned;
    logic                      w_mem_we;

    always_comb begin
        w_next   = r_state;
        w_ready  = (r_state != S_WAIT);
        w_accept = w_ready && (i_read || i_write);
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept)
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                else if (r_state == S_RESP)
                    w_next = S_IDLE;
            end
            S_WAIT: begin
                if (r_count == 4'd0)
                    w_next = S_RESP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Every transition into RESP (including RESP->RESP at LATENCY=1) is a response edge.
    assign w_enter_resp = (w_next == S_RESP);

    // With LATENCY=1 acceptance and response share an edge, so the live inputs
    // are the transaction; otherwise the values latched at acceptance are used.
    assign w_txn_addr  = (r_state == S_WAIT) ? r_addr     : i_address;
    assign w_txn_data  = (r_state == S_WAIT) ? r_data     : i_store_data;
    assign w_txn_write = (r_state == S_WAIT) ? r_is_write : i_write;
    assign w_idx       = w_txn_addr[MEM_DEPTH_BITS+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = (w_txn_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Gate with reset so a store presented while reset is high never commits.
    assign w_mem_we = w_enter_resp && w_txn_write && !w_misaligned && !i_reset;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= 4'd0;
            r_addr      <= '0;
            r_data      <= '0;
            r_is_write  <= 1'b0;
            r_load_data <= '0;
            r_data_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= i_address;
                r_data     <= i_store_data;
                r_is_write <= i_write;
                r_count    <= LAT_M2;
            end else if (r_state == S_WAIT && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
            if (w_enter_resp) begin
                r_data_addr <= w_txn_addr;
                if (w_txn_write || w_misaligned)
                    r_load_data <= '0;
                else
                    r_load_data <= r_mem[w_idx];
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_error;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_error <= 1'b0;
        else if (w_enter_resp)
            r_error <= w_misaligned;
    end
    assign o_error = r_error;
`endif

    // Array contents are intentionally not reset.
    always_ff @(posedge i_clock) begin
        if (w_mem_we)
            r_mem[w_idx] <= w_txn_data;
    end

    assign o_ready     = w_ready;
    assign o_valid     = (r_state == S_RESP);
    assign o_load_data = r_load_data;
    assign o_data_addr = r_data_addr;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder (LATENCY 1, 2 and 4)
module tb_data_mem_responder;

    logic        clk;
    logic        rst [3];
    logic        rd  [3];
    logic        wr  [3];
    logic [19:0] ad  [3];
    logic [31:0] sd  [3];
    logic        rdy [3];
    logic        vld [3];
    logic [31:0] ld  [3];
    logic [19:0] dad [3];
`ifdef DMEM_ALIGN_CHECK_EN
    logic        err [3];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word array per instance plus addresses known to hold data.
    logic [31:0] mm [3][1024];
    logic [19:0] wlist [3][$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(.LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .i_clock      (clk),
            .i_reset      (rst[g]),
            .i_read       (rd[g]),
            .i_write      (wr[g]),
            .i_address    (ad[g]),
            .i_store_data (sd[g]),
            .o_ready      (rdy[g]),
            .o_valid      (vld[g]),
            .o_load_data  (ld[g]),
            .o_data_addr  (dad[g])
`ifdef DMEM_ALIGN_CHECK_EN
            ,
            .o_error      (err[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic int idx_of(input logic [19:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request on instance k starting at a negedge; returns at the
    // negedge where the response is visible.
    task automatic txn(input int k, input bit r, input bit w, input logic [19:0] a, input logic [31:0] d);
        int n;
        bit mis;
        logic [31:0] exp;
        n = 0;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_req", 64'(rdy[k]), 64'd1);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp = (w || mis) ? 32'd0 : mm[k][idx_of(a)];
        rd[k] = r; wr[k] = w; ad[k] = a; sd[k] = d;
        @(negedge clk);
        rd[k] = 1'b0; wr[k] = 1'b0;
        n = 1;
        if (lat_of(k) > 1)
            check_eq("ready_busy", 64'(rdy[k]), 64'd0);
        while (!vld[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("latency", 64'(n), 64'(lat_of(k)));
        check_eq("valid", 64'(vld[k]), 64'd1);
        check_eq("load_data", 64'(ld[k]), 64'(exp));
        check_eq("data_addr", 64'(dad[k]), 64'(a));
        check_eq("ready_resp", 64'(rdy[k]), 64'd1);
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("error", 64'(err[k]), 64'(mis));
`endif
        if (w && !mis) begin
            mm[k][idx_of(a)] = d;
            wlist[k].push_back(a);
        end
    endtask

    function automatic logic [19:0] rand_addr();
        logic [19:0] a;
        a = 20'($urandom);
`ifdef DMEM_ALIGN_CHECK_EN
        a[1:0] = 2'b00;
`endif
        return a;
    endfunction

    initial begin
        logic [19:0] a;
        logic [19:0] prev;
        int op;
        int cnt;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; sd[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Reset then idle on LATENCY=2.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_ready", 64'(rdy[1]), 64'd1);
            check_eq("idle_valid", 64'(vld[1]), 64'd0);
            check_eq("idle_load_data", 64'(ld[1]), 64'd0);
            check_eq("idle_data_addr", 64'(dad[1]), 64'd0);
        end

        // Store then load on LATENCY=2.
        txn(1, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF);
        txn(1, 1'b1, 1'b0, 20'h00010, 32'h0);
        check_eq("deadbeef", 64'(ld[1]), 64'hDEADBEEF);

        // read and write together act as a store.
        txn(1, 1'b1, 1'b1, 20'h00020, 32'h12345678);
        txn(1, 1'b1, 1'b0, 20'h00020, 32'h0);
        check_eq("rw_both", 64'(ld[1]), 64'h12345678);

        // Randomized traffic on every latency.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 30; t++) begin
                op = int'($urandom_range(0, 2));
                if (op == 2 && wlist[k].size() > 0) begin
                    a = wlist[k][$urandom_range(0, wlist[k].size() - 1)];
                    // Upper bits above the index are ignored by the array.
                    a[19:12] = 8'($urandom);
`ifndef DMEM_ALIGN_CHECK_EN
                    a[1:0] = 2'($urandom);
`endif
                    txn(k, 1'b1, 1'b0, a, 32'h0);
                end else begin
                    txn(k, op == 1, 1'b1, rand_addr(), $urandom);
                end
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    check_eq("valid_one_cycle", 64'(vld[k]), 64'd0);
                end
            end
        end

        // Back-to-back loads held on read, LATENCY=1.
        @(negedge clk);
        prev = wlist[0][0];
        rd[0] = 1'b1; ad[0] = prev;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("b2b_valid", 64'(vld[0]), 64'd1);
            check_eq("b2b_ready", 64'(rdy[0]), 64'd1);
            check_eq("b2b_load_data", 64'(ld[0]), 64'(mm[0][idx_of(prev)]));
            check_eq("b2b_data_addr", 64'(dad[0]), 64'(prev));
            prev = wlist[0][$urandom_range(0, wlist[0].size() - 1)];
            ad[0] = prev;
        end
        rd[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b_end_valid", 64'(vld[0]), 64'd0);

        // Reset during WAIT of a store, LATENCY=4.
        txn(2, 1'b0, 1'b1, 20'h00030, 32'h11112222);
        @(negedge clk);
        wr[2] = 1'b1; ad[2] = 20'h00030; sd[2] = 32'hAAAA5555;
        @(negedge clk);
        wr[2] = 1'b0;
        check_eq("rst_pre_ready", 64'(rdy[2]), 64'd0);
        #2 rst[2] = 1'b1;
        #1;
        check_eq("rst_ready_now", 64'(rdy[2]), 64'd1);
        check_eq("rst_valid_now", 64'(vld[2]), 64'd0);
        check_eq("rst_load_data", 64'(ld[2]), 64'd0);
        check_eq("rst_data_addr", 64'(dad[2]), 64'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vld[2]) cnt++;
        end
        check_eq("rst_no_valid", 64'(cnt), 64'd0);
        txn(2, 1'b1, 1'b0, 20'h00030, 32'h0);
        check_eq("rst_prior_contents", 64'(ld[2]), 64'h11112222);

`ifdef DMEM_ALIGN_CHECK_EN
        txn(1, 1'b0, 1'b1, 20'h00040, 32'hCAFEF00D);
        txn(1, 1'b0, 1'b1, 20'h00042, 32'h55555555);
        check_eq("misaligned_error", 64'(err[1]), 64'd1);
        txn(1, 1'b1, 1'b0, 20'h00040, 32'h0);
        check_eq("aligned_unchanged", 64'(ld[1]), 64'hCAFEF00D);
        check_eq("aligned_error", 64'(err[1]), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data-memory responder that serves load/store requests from the memory stage and returns `load_data`, `valid`, `ready` and the echoed `data_addr` that the MEM/WB pipeline register captures. It is the memory-side end of the memory-stage request interface. It holds a synchronous word array and responds after a fixed, parameterised latency using a single-outstanding ready/valid handshake.

## Interface
- `DATA_WIDTH`, 32: word width.
- `ADDRESS_BITS`, 20: byte-address width.
- `MEM_DEPTH_BITS`, 10: log2 of array depth in words; index = `address[MEM_DEPTH_BITS+1:2]`, upper address bits ignored.
- `LATENCY`, 2: acceptance-to-response cycles, legal range 1..15.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `read` in 1: load request.
- `write` in 1: store request.
- `address` in ADDRESS_BITS: byte address of request.
- `store_data` in DATA_WIDTH: store word.
- `ready` out 1: responder can accept a request this cycle.
- `valid` out 1: one-cycle response pulse.
- `load_data` out DATA_WIDTH: load result; 0 for store responses.
- `data_addr` out ADDRESS_BITS: address of the transaction being responded to.
- `error` out 1: misaligned-access flag (only with `DMEM_ALIGN_CHECK_EN`).

## Operation
- States: IDLE (ready=1, valid=0), WAIT (ready=0, valid=0, counter counts down), RESP (ready=1, valid=1).
- Request accepted on a rising edge where `ready` and (`read` or `write`); `address`, `store_data` and the op type are latched.
- `read` and `write` both high: treated as write; read ignored.
- Acceptance: LATENCY=1 goes to RESP; otherwise goes to WAIT with counter = LATENCY-2, and WAIT goes to RESP on the edge where the counter is 0.
- On the RESP entry edge:
  - store: `mem[idx]` <= latched data, `load_data` <= 0.
  - load: `load_data` <= `mem[idx]`.
  - `data_addr` <= latched address.
- RESP with a new request accepted follows the same transition as IDLE acceptance. RESP with no request goes to IDLE.
- Outputs `load_data` and `data_addr` hold their values until the next RESP entry.
- Array contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset values: `ready`=1, `valid`=0, `load_data`=0, `data_addr`=0, `error`=0, state IDLE, counter 0.
- `valid` is high in the cycle following the LATENCY-th edge after acceptance, for exactly one cycle.
- Maximum throughput: one request per LATENCY cycles. A request presented during RESP is accepted at the edge that ends RESP.
- Requests while `ready`=0 are ignored; the requester must hold or re-present them.
- Read-after-write to the same word in back-to-back transactions returns the new data, because the write commits before the next read samples.
- Reset mid-transaction drops the pending transaction, and an uncommitted store is not written.
- `reset` takes effect immediately, without waiting for a clock edge.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - `error` port exists.
  - An accepted request with `address[1:0]`≠0 still completes the normal handshake and latency.
  - Its response has `error`=1 and `load_data`=0, and the store is suppressed.
  - `error` is 0 on aligned responses, and is updated only at RESP entry.
- Not defined: no `error` port, and `address[1:0]` is ignored.

## Test plan
- Reset then idle, LATENCY=2: `ready`=1, `valid`=0, `load_data`=0, `data_addr`=0 for 10 cycles.
- Store 0xDEADBEEF to 0x00010, then load 0x00010, LATENCY=2:
  - store response has `valid` pulse 2 cycles after acceptance, `load_data`=0, `data_addr`=0x00010.
  - load response has `load_data`=0xDEADBEEF.
- Back-to-back loads held on `read` with LATENCY=1: one `valid` per cycle after the first, `ready` never drops.
- `read`=`write`=1, addr 0x00020, data 0x12345678: treated as store; a subsequent load of 0x00020 returns 0x12345678.
- `reset` pulsed during WAIT of a store of 0xAAAA5555 to 0x00030, with LATENCY=4:
  - no `valid`; `ready`=1 immediately.
  - a later load of 0x00030 returns the prior contents.
- With `DMEM_ALIGN_CHECK_EN`, store to 0x00042: `valid` with `error`=1; a load of 0x00040 is unchanged; an aligned access gives `error`=0.
